// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings and shadow-stage record for the hazard/forward unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_forward_unit_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  // Operand mux select encodings
  localparam logic [1:0] SEL_RF  = 2'b00;  // register-file value
  localparam logic [1:0] SEL_WB  = 2'b01;  // MEM/WB write-back data
  localparam logic [1:0] SEL_MEM = 2'b10;  // EX/MEM ALU result

  // Destination info tracked per shadow pipeline stage
  typedef struct packed {
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      regwrite;
    logic                      memread;
  } stage_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority compare choosing the forwarding source for one EX operand.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_regwrite_i,
  output logic [1:0]            sel_o
);

  logic mem_hit;
  logic wb_hit;

  // Register 0 is hard-wired, so a write to it never provides a value
  assign mem_hit = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src_i);
  assign wb_hit  = wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == src_i);

  // Youngest producer (EX/MEM) wins over the older MEM/WB one
  always_comb begin
    sel_o = SEL_RF;
    if (mem_hit) begin
      sel_o = SEL_MEM;
    end else if (wb_hit) begin
      sel_o = SEL_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding selects, load-use stall and stall counter for the 5-stage pipe.
// Latency: selects/stall combinational from shadow state; shadow advances each clock.
// Backpressure: stall_o holds PC and IF/ID for one cycle per load-use hazard.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  flush_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  // Shadow pipeline: EX also keeps its source registers for the compare
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
  stage_t                ex_q, ex_d;
  stage_t                mem_q;
  stage_t                wb_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic hazard;
  logic load_ex;
  logic unused_memread;

  // A load in EX whose rd is read by the ID instruction cannot be forwarded in time
  assign hazard = ex_q.memread && (ex_q.rd != '0) && id_valid_i &&
                  ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));

  // A flushed ID instruction is discarded, so there is nothing to stall for
  assign stall_o = hazard && !flush_i;
  assign load_ex = id_valid_i && !stall_o && !flush_i;

  // Memread only matters while the load sits in EX; later copies are informational
  assign unused_memread = mem_q.memread | wb_q.memread;

  // ID->EX: take the ID fields or insert an all-zero bubble
  always_comb begin
    ex_rs1_d = '0;
    ex_rs2_d = '0;
    ex_d     = '0;
    if (load_ex) begin
      ex_rs1_d    = id_rs1_i;
      ex_rs2_d    = id_rs2_i;
      ex_d.rd       = id_rd_i;
      ex_d.regwrite = id_regwrite_i;
      ex_d.memread  = id_memread_i;
    end
  end

  // Saturating stall counter: holds at all-ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Shadow stages and counter advance every clock; reset clears all of them
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      cnt_q    <= '0;
    end else begin
      ex_rs1_q <= ex_rs1_d;
      ex_rs2_q <= ex_rs2_d;
      ex_q     <= ex_d;
      mem_q    <= ex_q;
      wb_q.rd       <= mem_q.rd;
      wb_q.regwrite <= mem_q.regwrite;
      wb_q.memread  <= 1'b0;
      cnt_q    <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src_i          (ex_rs1_q),
    .mem_rd_i       (mem_q.rd),
    .mem_regwrite_i (mem_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .wb_regwrite_i  (wb_q.regwrite),
    .sel_o          (fwd_a_o)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src_i          (ex_rs2_q),
    .mem_rd_i       (mem_q.rd),
    .mem_regwrite_i (mem_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .wb_regwrite_i  (wb_q.regwrite),
    .sel_o          (fwd_b_o)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed instruction streams.
// Latency: checks selects in the consumer's EX cycle, stall in its ID cycle.
// Backpressure: bench re-presents the ID instruction while stall_o is high.
module tb_hazard_forward_unit;

  localparam int TB_CNT_W = 10;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk_i = 1'b0;
  logic                rst_n_i;
  logic                id_valid_i;
  logic [4:0]          id_rs1_i, id_rs2_i, id_rd_i;
  logic                id_regwrite_i, id_memread_i, flush_i;
  logic [1:0]          fwd_a_o, fwd_b_o;
  logic                stall_o;
  logic [TB_CNT_W-1:0] stall_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(TB_CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .stall_o       (stall_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  // Instruction records in flight: index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr;
  } ins_t;

  ins_t m_pipe [3];
  int   m_cnt;

  // Search older instructions from youngest to oldest for the first writer of src.
  function automatic logic [1:0] m_sel(input logic [4:0] src);
    for (int k = 1; k <= 2; k++) begin
      if (m_pipe[k].rw && m_pipe[k].rd != 5'd0 && m_pipe[k].rd == src)
        return (k == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    ins_t ex;
    ex = m_pipe[0];
    return ex.mr && ex.rd != 5'd0 && id_valid_i &&
           (ex.rd == id_rs1_i || ex.rd == id_rs2_i) && !flush_i;
  endfunction

  always @(posedge clk_i or negedge rst_n_i) begin : model
    ins_t nxt;
    if (!rst_n_i) begin
      for (int i = 0; i < 3; i++) m_pipe[i] <= '0;
      m_cnt <= 0;
    end else begin
      nxt = '0;
      if (id_valid_i && !flush_i && !m_stall())
        nxt = '{rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i, rw: id_regwrite_i, mr: id_memread_i};
      m_pipe[2] <= m_pipe[1];
      m_pipe[1] <= m_pipe[0];
      m_pipe[0] <= nxt;
      if (m_stall()) m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk_i) begin
    chk("cyc_fwd_a", fwd_a_o, m_sel(m_pipe[0].rs1));
    chk("cyc_fwd_b", fwd_b_o, m_sel(m_pipe[0].rs2));
    chk("cyc_stall", stall_o, m_stall());
    chk("cyc_cnt", stall_cnt_o, m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    @(posedge clk_i);
    #2;
    id_valid_i    = v;
    id_rs1_i      = r1;
    id_rs2_i      = r2;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    flush_i       = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held with arbitrary (load-like) ID inputs
    rst_n_i = 1'b0;
    id_valid_i = 1'b1; id_rs1_i = 5'd9; id_rs2_i = 5'd9; id_rd_i = 5'd9;
    id_regwrite_i = 1'b1; id_memread_i = 1'b1; flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_fwd_a", fwd_a_o, 2'b00);
    chk("rst_fwd_b", fwd_b_o, 2'b00);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_cnt", stall_cnt_o, 0);
    @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    idle(3);

    // EX/MEM forward on both operands
    step(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);     // add x5
    step(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);     // sub rs1=rs2=x5
    idle(1);
    #2 chk("exmem_a", fwd_a_o, 2'b10);
    chk("exmem_b", fwd_b_o, 2'b10);
    idle(3);

    // MEM/WB forward
    step(1, 5'd0, 5'd0, 5'd7, 1, 0, 0);
    step(1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
    step(1, 5'd7, 5'd0, 5'd8, 1, 0, 0);
    idle(1);
    #2 chk("memwb_a", fwd_a_o, 2'b01);
    chk("memwb_b", fwd_b_o, 2'b00);
    idle(3);

    // Priority: both stages write x7, youngest wins
    step(1, 5'd0, 5'd0, 5'd7, 1, 0, 0);
    step(1, 5'd0, 5'd0, 5'd7, 1, 0, 0);
    step(1, 5'd7, 5'd0, 5'd8, 1, 0, 0);
    idle(1);
    #2 chk("prio_a", fwd_a_o, 2'b10);
    idle(3);

    // Register zero never forwards
    step(1, 5'd1, 5'd1, 5'd0, 1, 0, 0);
    step(1, 5'd0, 5'd0, 5'd4, 1, 0, 0);
    idle(1);
    #2 chk("x0_a", fwd_a_o, 2'b00);
    chk("x0_b", fwd_b_o, 2'b00);
    idle(3);

    // Load-use: one stall, bubble, then WB forward
    step(1, 5'd0, 5'd0, 5'd9, 1, 1, 0);     // lw x9
    step(1, 5'd1, 5'd9, 5'd4, 1, 0, 0);     // use x9 on rs2
    #2 chk("lu_stall_on", stall_o, 1'b1);
    chk("lu_cnt0", stall_cnt_o, 0);
    step(1, 5'd1, 5'd9, 5'd4, 1, 0, 0);     // held instruction advances
    #2 chk("lu_stall_off", stall_o, 1'b0);
    chk("lu_cnt1", stall_cnt_o, 1);
    chk("lu_bubble_a", fwd_a_o, 2'b00);
    chk("lu_bubble_b", fwd_b_o, 2'b00);
    idle(1);
    #2 chk("lu_fwd_b", fwd_b_o, 2'b01);
    chk("lu_fwd_a", fwd_a_o, 2'b00);
    idle(3);

    // Flush beats hazard; count unchanged
    step(1, 5'd0, 5'd0, 5'd9, 1, 1, 0);
    step(1, 5'd1, 5'd9, 5'd4, 1, 0, 1);
    #2 chk("fl_stall", stall_o, 1'b0);
    chk("fl_cnt", stall_cnt_o, 1);
    idle(1);
    #2 chk("fl_bubble_b", fwd_b_o, 2'b00);
    idle(3);

    // Flush leaves older instructions forwarding
    step(1, 5'd0, 5'd0, 5'd12, 1, 0, 0);
    step(1, 5'd12, 5'd0, 5'd6, 1, 0, 0);
    step(1, 5'd12, 5'd12, 5'd8, 1, 0, 1);
    #2 chk("fl_keep_a", fwd_a_o, 2'b10);
    idle(3);

    // Chained loads: one stall per dependent instruction
    step(1, 5'd0, 5'd0, 5'd9, 1, 1, 0);     // lw x9
    step(1, 5'd9, 5'd0, 5'd10, 1, 1, 0);    // lw x10, 0(x9): stall
    step(1, 5'd9, 5'd0, 5'd10, 1, 1, 0);
    step(1, 5'd10, 5'd0, 5'd11, 1, 0, 0);   // use x10: stall
    step(1, 5'd10, 5'd0, 5'd11, 1, 0, 0);
    idle(1);
    #2 chk("chain_fwd_a", fwd_a_o, 2'b01);
    chk("chain_cnt", stall_cnt_o, 3);
    idle(3);

    // Asynchronous reset mid-cycle
    step(1, 5'd0, 5'd0, 5'd5, 1, 0, 0);
    step(1, 5'd5, 5'd0, 5'd6, 1, 0, 0);
    idle(1);
    #1 chk("pre_arst_a", fwd_a_o, 2'b10);
    rst_n_i = 1'b0;
    #1 chk("arst_a", fwd_a_o, 2'b00);
    chk("arst_b", fwd_b_o, 2'b00);
    chk("arst_stall", stall_o, 1'b0);
    chk("arst_cnt", stall_cnt_o, 0);
    @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    idle(2);

    // Saturation: self-dependent loads stall every other cycle
    for (int i = 0; i < 2 * (CNT_MAX + 1 + 3) + 4; i++)
      step(1, 5'd9, 5'd9, 5'd9, 1, 1, 0);
    #2 chk("sat_cnt", stall_cnt_o, CNT_MAX);
    idle(2);
    #2 chk("sat_hold", stall_cnt_o, CNT_MAX);

    @(posedge clk_i);
    #2 $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
